rgb_pwm_driver: RTL
===================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 1, meaning: clk cycles per PWM tick (range 1..65535).
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  run request; low forces outputs low and holds counters cleared.
REQ-005 rgb  input  24  colour word from the colour converter: [23:16] red, [15:8] green, [7:0] blue duty.
REQ-006 load  input  1  single-cycle strobe; captures rgb into shadow register.
REQ-007 pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive per channel.
REQ-008 period_start  output  1  one-clk pulse on the cycle the new duty set becomes active.
REQ-009 pending  output  1  shadow holds a value not yet transferred to active duty.

Function
REQ-010 The block SHALL have states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0, next clk edge.
REQ-011 The block SHALL generate a tick every PRESCALE clk cycles in RUN via a prescale counter 0..PRESCALE-1; the prescaler is held at 0 in IDLE.
REQ-012 The block SHALL keep an 8-bit period counter cnt that advances 0..255 by one per tick and wraps 255->0.
REQ-013 On load=1 (any state), the block SHALL capture rgb into shadow on that edge and set pending=1.
REQ-014 At a period boundary (tick with cnt=255, or IDLE->RUN entry), the block SHALL copy shadow to active duty if pending=1, clear pending, and pulse period_start for one clk.
REQ-015 Active duty SHALL never change except at REQ-014 boundaries (glitch-free mid-period).
REQ-016 load coincident with a boundary: transfer SHALL use the shadow value held before the edge; the new rgb SHALL land in shadow with pending=1 for the following boundary.
REQ-017 pwm_x SHALL be registered as (cnt < duty_x), updated on each tick: duty 0 -> constantly low; duty 255 -> high 255 of 256 ticks; duty N -> high N ticks per period, starting at cnt=0.
REQ-018 Output latency SHALL be one clk from the tick edge at which cnt changes to the corresponding pwm update.
REQ-019 In IDLE, pwm_r/g/b and period_start SHALL be 0; cnt=0; shadow, active duty and pending SHALL be retained.
REQ-020 Re-entering RUN SHALL start a fresh period at cnt=0 with REQ-014 transfer.

Reset
REQ-021 rst_n=0 SHALL asynchronously force: state IDLE, cnt=0, prescaler=0, shadow=0, active duty=0, pending=0, all outputs 0.
REQ-022 Reset assertion mid-period SHALL take effect immediately without waiting for clk; release SHALL be sampled synchronously.

Structure
REQ-023 A shared package SHALL hold DUTY_W=8, RGB_W=24, channel bit-slice constants and the IDLE/RUN state encoding.
REQ-024 One sub-module pwm_channel (8-bit duty register plus comparator and output flop) SHALL be instantiated three times; cnt, prescaler, shadow and FSM stay in the top.

Verification (PRESCALE=1 unless stated)
REQ-025 Reset: assert rst_n=0 mid-run -> pwm_r/g/b=0, pending=0, period_start=0 same cycle, before next clk edge.
REQ-026 load rgb=24'hFF0000, then enable=1 -> period_start pulse, pending 0; pwm_r high 255/256 clk, pwm_g and pwm_b low all 256 clk.
REQ-027 rgb=24'h804000 loaded and active -> per 256-clk period pwm_r high 128 clk, pwm_g high 64 clk, pwm_b 0 clk.
REQ-028 Mid-period load 24'h0000FF at cnt=100 -> old duty persists to cnt=255, pending=1 until boundary; next period pwm_b high 255 clk.
REQ-029 load at the boundary cycle -> old shadow transferred; new value active one period later; pending=1 throughout that period.
REQ-030 enable dropped at cnt=50 -> outputs 0 next clk; re-enable -> period_start pulse, cnt restarts at 0; PRESCALE=4 run -> period = 1024 clk.

Source files
------------

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared widths, colour-word slice positions and FSM encoding for the RGB PWM driver.
package rgb_pwm_driver_pkg;

    localparam int unsigned DUTY_W    = 8;
    localparam int unsigned RGB_W     = 24;
    localparam int unsigned RED_LSB   = 16;
    localparam int unsigned GREEN_LSB = 8;
    localparam int unsigned BLUE_LSB  = 0;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, period comparator and registered output.
module pwm_channel
    import rgb_pwm_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load_duty,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic [DUTY_W-1:0] cnt,
    output logic              pwm
);

    logic [DUTY_W-1:0] duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load_duty) begin
                duty_q <= duty_in;
            end
            pwm <= run && (cnt < duty_q);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver with double-buffered duty; new colours take effect only at
// period boundaries so a running period never glitches.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [RGB_W-1:0] rgb,
    input  logic             load,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             period_start,
    output logic             pending
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    state_e            state_q;
    logic [15:0]       presc_q;
    logic [DUTY_W-1:0] cnt_q;
    logic [RGB_W-1:0]  shadow_q;
    logic              pending_q;
    logic              period_start_q;

    logic running;
    logic tick;
    logic boundary;
    logic transfer;

    // Gating with enable lets outputs and counters drop on the very next edge.
    assign running  = (state_q == StRun) && enable;
    assign tick     = running && (presc_q == PRESC_MAX);
    assign boundary = ((state_q == StIdle) && enable) || (tick && (cnt_q == 8'hFF));
    assign transfer = boundary && pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            presc_q        <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q <= enable ? StRun : StIdle;

            if (!running) begin
                presc_q <= '0;
            end else if (tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 16'd1;
            end

            if (!running) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end

            period_start_q <= boundary;

            // A load on the boundary edge refills the shadow after the old value moves out.
            if (load) begin
                shadow_q  <= rgb;
                pending_q <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
        end
    end

    pwm_channel u_red (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (running),
        .load_duty (transfer),
        .duty_in   (shadow_q[RED_LSB +: DUTY_W]),
        .cnt       (cnt_q),
        .pwm       (pwm_r)
    );

    pwm_channel u_green (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (running),
        .load_duty (transfer),
        .duty_in   (shadow_q[GREEN_LSB +: DUTY_W]),
        .cnt       (cnt_q),
        .pwm       (pwm_g)
    );

    pwm_channel u_blue (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (running),
        .load_duty (transfer),
        .duty_in   (shadow_q[BLUE_LSB +: DUTY_W]),
        .cnt       (cnt_q),
        .pwm       (pwm_b)
    );

    assign period_start = period_start_q;
    assign pending      = pending_q;

endmodule
